// File: rtl/reg_file_ctrl_pkg.sv
// Shared constants for the register-file port sequencer: state encoding
// and default widths that must agree with the register file instance.
package reg_file_ctrl_pkg;

   localparam int REG_WIDTH_DEF  = 32;
   localparam int ADDR_WIDTH_DEF = 4;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WR0  = 3'd1;
   localparam logic [2:0] ST_WR1  = 3'd2;
   localparam logic [2:0] ST_RS1  = 3'd3;
   localparam logic [2:0] ST_RS2  = 3'd4;
   localparam logic [2:0] ST_CAP  = 3'd5;
   localparam logic [2:0] ST_DONE = 3'd6;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      WR0  = ST_WR0,
      WR1  = ST_WR1,
      RS1  = ST_RS1,
      RS2  = ST_RS2,
      CAP  = ST_CAP,
      DONE = ST_DONE
   } state_e;

endpackage

// File: rtl/reg_file_port_seq_if.sv
// Handshake bundle between decode/writeback and the port sequencer.
// Groups: req_* (operand request), out_* (operands back), wb_* (write).
// slave  = sequencer side, master = decode/writeback side.
interface reg_file_port_seq_if
   import reg_file_ctrl_pkg::*;
#(
   parameter int REG_WIDTH  = REG_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_rs1;
   logic [ADDR_WIDTH-1:0] req_rs2;

   logic                  out_valid;
   logic                  out_ready;
   logic [REG_WIDTH-1:0]  out_rs1_data;
   logic [REG_WIDTH-1:0]  out_rs2_data;

   logic                  wb_valid;
   logic                  wb_ready;
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic [REG_WIDTH-1:0]  wb_data;

   modport slave (
      input  req_valid, req_rs1, req_rs2,
      output req_ready,
      output out_valid, out_rs1_data, out_rs2_data,
      input  out_ready,
      input  wb_valid, wb_addr, wb_data,
      output wb_ready
   );

   modport master (
      output req_valid, req_rs1, req_rs2,
      input  req_ready,
      input  out_valid, out_rs1_data, out_rs2_data,
      output out_ready,
      output wb_valid, wb_addr, wb_data,
      input  wb_ready
   );

endinterface

// File: rtl/reg_file_port_seq.sv
// Shares a single-port register file between decode (two reads per
// request, returned together) and writeback (one write, priority).
// Ports: clk, rst_n (sync, active-low); bus (slave modport: req_*, out_*,
// wb_*); rf_read_en/rf_write_en/rf_addr/rf_wr_data to the register file;
// rf_rd_data_val/rf_rd_data from it; busy = not idle.
// Option: define REGFILE_X0_ZERO_EN to make address 0 read as zero and
// drop writes to it.
module reg_file_port_seq
   import reg_file_ctrl_pkg::*;
#(
   parameter int REG_WIDTH  = REG_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   reg_file_port_seq_if.slave    bus,
   output logic                  rf_read_en,
   output logic                  rf_write_en,
   output logic [ADDR_WIDTH-1:0] rf_addr,
   output logic [REG_WIDTH-1:0]  rf_wr_data,
   input  logic                  rf_rd_data_val,
   input  logic [REG_WIDTH-1:0]  rf_rd_data,
   output logic                  busy
);

   state_e                state_q, state_d;
   logic                  rd_en_q, rd_en_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
   logic [REG_WIDTH-1:0]  d1_q, d1_d;
   logic [REG_WIDTH-1:0]  d2_q, d2_d;
   logic                  vld_q, vld_d;
   logic [ADDR_WIDTH-1:0] rs2_q;

   logic accept;
   logic wb_fire;
   logic req_fire;
   logic wr_drop;
   logic cap1_zero;
   logic cap2_zero;

   // Only IDLE and WR1 can take new work; writes always win.
   assign accept        = (state_q == IDLE) || (state_q == WR1);
   assign bus.wb_ready  = accept;
   assign bus.req_ready = accept && !bus.wb_valid;
   assign wb_fire       = bus.wb_valid && bus.wb_ready;
   assign req_fire      = bus.req_valid && bus.req_ready;

`ifdef REGFILE_X0_ZERO_EN
   logic z1_q, z2_q;

   assign wr_drop   = (bus.wb_addr == '0);
   assign cap1_zero = z1_q;
   assign cap2_zero = z2_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         z1_q <= 1'b0;
         z2_q <= 1'b0;
      end else if (req_fire) begin
         z1_q <= (bus.req_rs1 == '0);
         z2_q <= (bus.req_rs2 == '0);
      end
   end
`else
   assign wr_drop   = 1'b0;
   assign cap1_zero = 1'b0;
   assign cap2_zero = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      rd_en_d = 1'b0;
      wr_en_d = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      vld_d   = 1'b0;
      unique case (state_q)
         IDLE, WR1: begin
            state_d = IDLE;
            if (wb_fire) begin
               if (!wr_drop) begin
                  state_d = WR0;
                  wr_en_d = 1'b1;
                  addr_d  = bus.wb_addr;
                  wdata_d = bus.wb_data;
               end
            end else if (req_fire) begin
               state_d = RS1;
               rd_en_d = 1'b1;
               addr_d  = bus.req_rs1;
            end
         end
         // addr/data held: the register file commits one cycle later
         WR0: state_d = WR1;
         RS1: begin
            state_d = RS2;
            rd_en_d = 1'b1;
            addr_d  = rs2_q;
         end
         RS2: begin
            if (rf_rd_data_val) begin
               state_d = CAP;
               d1_d    = cap1_zero ? '0 : rf_rd_data;
            end else begin
               rd_en_d = 1'b1;
            end
         end
         CAP: begin
            if (rf_rd_data_val) begin
               state_d = DONE;
               vld_d   = 1'b1;
               d2_d    = cap2_zero ? '0 : rf_rd_data;
            end else begin
               rd_en_d = 1'b1;
            end
         end
         DONE: begin
            vld_d = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
               vld_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         vld_q   <= 1'b0;
         rs2_q   <= '0;
      end else begin
         state_q <= state_d;
         rd_en_q <= rd_en_d;
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         vld_q   <= vld_d;
         if (req_fire) rs2_q <= bus.req_rs2;
      end
   end

   assign rf_read_en       = rd_en_q;
   assign rf_write_en      = wr_en_q;
   assign rf_addr          = addr_q;
   assign rf_wr_data       = wdata_q;
   assign bus.out_valid    = vld_q;
   assign bus.out_rs1_data = d1_q;
   assign bus.out_rs2_data = d2_q;
   assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_reg_file_port_seq.sv
// Bench for reg_file_port_seq: register file environment model plus a
// plain array of expected register contents.
module tb_reg_file_port_seq;
   import reg_file_ctrl_pkg::*;

   localparam int RW = 32;
   localparam int AW = 4;
`ifdef REGFILE_X0_ZERO_EN
   localparam bit X0 = 1'b1;
`else
   localparam bit X0 = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rf_read_en, rf_write_en, busy;
   logic [AW-1:0] rf_addr;
   logic [RW-1:0] rf_wr_data;
   logic          rf_rd_data_val = 1'b0;
   logic [RW-1:0] rf_rd_data = '0;

   reg_file_port_seq_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) bus();

   reg_file_port_seq #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
      .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
      .rf_rd_data_val(rf_rd_data_val), .rf_rd_data(rf_rd_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   logic [RW-1:0] seed [16];
   logic [RW-1:0] mem [16];
   logic [RW-1:0] ref_mem [16];
   logic          seeded = 1'b0;
   logic          wr_pend = 1'b0;
   int            wr_pulses = 0;
   int            n_chk = 0;
   int            n_fail = 0;

   // Register file: 1-cycle read, write decode registered (commits a
   // cycle after write_en using the held addr/data).
   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < 16; i++) mem[i] <= seed[i];
         seeded <= 1'b1;
      end else if (wr_pend) begin
         mem[rf_addr] <= rf_wr_data;
      end
      rf_rd_data_val <= rf_read_en;
      if (rf_read_en) rf_rd_data <= mem[rf_addr];
      wr_pend <= rf_write_en;
      if (rf_write_en) wr_pulses <= wr_pulses + 1;
   end

   function automatic logic [RW-1:0] exp_rd(input logic [AW-1:0] a);
      if (X0 && a == 0) return '0;
      return ref_mem[a];
   endfunction

   task automatic do_write(input logic [AW-1:0] a, input logic [RW-1:0] d,
                           output bit ok);
      @(negedge clk);
      bus.wb_valid = 1'b1;
      bus.wb_addr  = a;
      bus.wb_data  = d;
      #1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.wb_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      if (ok) begin
         @(posedge clk);
         if (!(X0 && a == 0)) ref_mem[a] = d;
      end
      #1 bus.wb_valid = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                          input bit release_out, output logic [RW-1:0] d1,
                          output logic [RW-1:0] d2, output int lat);
      bit ok;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_rs1   = r1;
      bus.req_rs2   = r2;
      #1;
      ok  = 1'b0;
      lat = -1;
      d1  = 'x;
      d2  = 'x;
      for (int i = 0; i < 20; i++) begin
         if (bus.req_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      if (!ok) begin
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
      d1 = bus.out_rs1_data;
      d2 = bus.out_rs2_data;
      if (release_out && lat > 0) begin
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1 bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({rf_read_en, rf_write_en, rf_addr, rf_wr_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_rf got %b %b %h %h want 0", rf_read_en,
                  rf_write_en, rf_addr, rf_wr_data);
      end
      n_chk++;
      if ({bus.out_valid, bus.out_rs1_data, bus.out_rs2_data, busy} !== '0)
      begin
         n_fail++;
         $display("FAIL reset_out got v=%b %h %h busy=%b want 0",
                  bus.out_valid, bus.out_rs1_data, bus.out_rs2_data, busy);
      end
      n_chk++;
      if ({bus.req_ready, bus.wb_ready} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_ready got %b%b want 11", bus.req_ready,
                  bus.wb_ready);
      end
      rst_n = 1'b1;
      // reset while the second read is on the port
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_rs1   = 4'd7;
      bus.req_rs2   = 4'd9;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if ({rf_read_en, rf_addr, busy} !== {1'b1, 4'd9, 1'b1}) begin
         n_fail++;
         $display("FAIL mid_rs2 got en=%b addr=%0d busy=%b want 1 9 1",
                  rf_read_en, rf_addr, busy);
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({bus.out_valid, rf_read_en, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL mid_reset got v=%b en=%b busy=%b want 000",
                  bus.out_valid, rf_read_en, busy);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      bit            ok;
      int            p0, lat;
      logic [RW-1:0] d1, d2;
      p0 = wr_pulses;
      do_write(4'd0, 32'h11, ok);
      repeat (3) @(negedge clk);
      n_chk++;
      if (!ok || (wr_pulses - p0) != (X0 ? 0 : 1)) begin
         n_fail++;
         $display("FAIL r0_write_pulses got %0d ok=%b want %0d",
                  wr_pulses - p0, ok, X0 ? 0 : 1);
      end
      do_write(4'd5, 32'hDEADBEEF, ok);
      do_read(4'd5, 4'd0, 1'b1, d1, d2, lat);
      n_chk++;
      if (lat != 4) begin
         n_fail++;
         $display("FAIL wr_rd_latency got %0d want 4", lat);
      end
      n_chk++;
      if (d1 !== 32'hDEADBEEF || d2 !== (X0 ? 32'h0 : 32'h11)) begin
         n_fail++;
         $display("FAIL wr_rd_data got %h %h want deadbeef %h", d1, d2,
                  X0 ? 32'h0 : 32'h11);
      end
   endtask

   task automatic test_collision();
      logic [RW-1:0] d1, d2;
      int            lat;
      @(negedge clk);
      bus.wb_valid  = 1'b1;
      bus.wb_addr   = 4'd3;
      bus.wb_data   = 32'h1234;
      bus.req_valid = 1'b1;
      bus.req_rs1   = 4'd3;
      bus.req_rs2   = 4'd3;
      #1;
      n_chk++;
      if ({bus.wb_ready, bus.req_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL coll_idle_ready got wb=%b req=%b want 1 0",
                  bus.wb_ready, bus.req_ready);
      end
      @(posedge clk);
      ref_mem[3] = 32'h1234;
      #1 bus.wb_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({bus.req_ready, rf_write_en} !== 2'b01) begin
         n_fail++;
         $display("FAIL coll_wr0 got req=%b we=%b want 0 1",
                  bus.req_ready, rf_write_en);
      end
      @(negedge clk);
      n_chk++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL coll_wr1_ready got %b want 1", bus.req_ready);
      end
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
      d1 = bus.out_rs1_data;
      d2 = bus.out_rs2_data;
      n_chk++;
      if (lat != 4 || d1 !== 32'h1234 || d2 !== 32'h1234) begin
         n_fail++;
         $display("FAIL coll_data got lat=%0d %h %h want 4 1234 1234",
                  lat, d1, d2);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   task automatic test_done_hold();
      logic [AW-1:0] a, b;
      logic [RW-1:0] d1, d2;
      int            lat;
      a = AW'($urandom_range(1, 15));
      b = AW'($urandom_range(0, 15));
      do_read(a, b, 1'b0, d1, d2, lat);
      n_chk++;
      if (lat != 4 || d1 !== exp_rd(a) || d2 !== exp_rd(b)) begin
         n_fail++;
         $display("FAIL hold_first got lat=%0d %h %h want 4 %h %h",
                  lat, d1, d2, exp_rd(a), exp_rd(b));
      end
      for (int i = 0; i < 10; i++) begin
         bus.req_valid = 1'b1;
         bus.wb_valid  = (i % 2) == 0;
         #1;
         n_chk++;
         if (!bus.out_valid || bus.out_rs1_data !== exp_rd(a) ||
             bus.out_rs2_data !== exp_rd(b) || bus.req_ready ||
             bus.wb_ready || !busy) begin
            n_fail++;
            $display("FAIL hold_cyc%0d got v=%b %h %h rr=%b wr=%b", i,
                     bus.out_valid, bus.out_rs1_data, bus.out_rs2_data,
                     bus.req_ready, bus.wb_ready);
         end
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      bus.wb_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release got busy=%b v=%b want 0 0", busy,
                  bus.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [RW-1:0] dat [5];
      logic [RW-1:0] d1, d2;
      int            lat;
      for (int i = 1; i <= 4; i++) dat[i] = $urandom;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_rs1   = 4'd1;
      bus.req_rs2   = 4'd2;
      bus.wb_valid  = 1'b1;
      bus.wb_addr   = 4'd1;
      bus.wb_data   = dat[1];
      #1;
      for (int i = 1; i <= 4; i++) begin
         n_chk++;
         if (bus.wb_ready !== 1'b1 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept%0d got wr=%b rr=%b want 1 0", i,
                     bus.wb_ready, bus.req_ready);
         end
         @(posedge clk);
         ref_mem[i] = dat[i];
         @(negedge clk);
         n_chk++;
         if (rf_write_en !== 1'b1 || rf_addr !== AW'(i) ||
             rf_wr_data !== dat[i] || bus.wb_ready || bus.req_ready) begin
            n_fail++;
            $display("FAIL b2b_wr0_%0d got we=%b a=%0d d=%h wr=%b rr=%b", i,
                     rf_write_en, rf_addr, rf_wr_data, bus.wb_ready,
                     bus.req_ready);
         end
         if (i < 4) begin
            bus.wb_addr = AW'(i + 1);
            bus.wb_data = dat[i + 1];
         end
         @(negedge clk);
         n_chk++;
         if (rf_write_en !== 1'b0 || rf_addr !== AW'(i) ||
             rf_wr_data !== dat[i] || bus.req_ready) begin
            n_fail++;
            $display("FAIL b2b_wr1_%0d got we=%b a=%0d d=%h rr=%b", i,
                     rf_write_en, rf_addr, rf_wr_data, bus.req_ready);
         end
         if (i == 4) begin
            bus.wb_valid  = 1'b0;
            bus.req_valid = 1'b0;
         end
         #1;
      end
      do_read(4'd1, 4'd2, 1'b1, d1, d2, lat);
      do_read(4'd3, 4'd4, 1'b1, d1, d2, lat);
      n_chk++;
      if (lat != 4 || d1 !== dat[3] || d2 !== dat[4]) begin
         n_fail++;
         $display("FAIL b2b_readback got lat=%0d %h %h want 4 %h %h", lat,
                  d1, d2, dat[3], dat[4]);
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] a, b;
      logic [RW-1:0] d1, d2;
      int            lat;
      bit            ok;
      for (int n = 0; n < 40; n++) begin
         a = AW'($urandom_range(0, 15));
         b = AW'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) begin
            do_write(a, $urandom, ok);
            n_chk++;
            if (!ok) begin
               n_fail++;
               $display("FAIL rnd_write%0d got no accept want accept", n);
            end
         end else begin
            do_read(a, b, 1'b1, d1, d2, lat);
            n_chk++;
            if (lat != 4 || d1 !== exp_rd(a) || d2 !== exp_rd(b)) begin
               n_fail++;
               $display("FAIL rnd_read%0d r%0d r%0d got lat=%0d %h %h want 4 %h %h",
                        n, a, b, lat, d1, d2, exp_rd(a), exp_rd(b));
            end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout waiting for the bench to finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         seed[i]    = $urandom | 32'h1;
         ref_mem[i] = seed[i];
      end
      bus.req_valid = 1'b0;
      bus.req_rs1   = '0;
      bus.req_rs2   = '0;
      bus.out_ready = 1'b0;
      bus.wb_valid  = 1'b0;
      bus.wb_addr   = '0;
      bus.wb_data   = '0;
      test_reset();
      test_write_read();
      test_collision();
      test_done_hold();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
